// File: rtl/stream_mux_pkg.sv
// Shared constants for the 2:1 stream merger and its companion 1x2 demux.
// SEL_CHn values match the demux select encoding so out_sel can drive it directly.
package stream_mux_pkg;
    localparam logic SEL_CH0          = 1'b0;
    localparam logic SEL_CH1          = 1'b1;
    localparam int   STREAM_W_DEFAULT = 8;
endpackage

// File: rtl/stream_mux_2x1_rr_arb_2.sv
// Purpose: 2-request arbiter, round-robin by default, fixed ch0 priority with STREAM_MUX_FIXED_PRIO_EN.
// Latency: combinational grant; the last-winner state updates on the edge where accept is high.
// Backpressure: none internally; the caller only asserts accept when the grant is actually taken.
module rr_arb_2
    import stream_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

`ifdef STREAM_MUX_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, accept};

    always_comb begin
        gnt     = 2'b00;
        gnt_idx = SEL_CH0;
        if (req[0]) begin
            gnt     = 2'b01;
            gnt_idx = SEL_CH0;
        end else if (req[1]) begin
            gnt     = 2'b10;
            gnt_idx = SEL_CH1;
        end
    end
`else
    // Reset to ch1 so ch0 wins the first contention.
    logic r_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= SEL_CH1;
        end else if (accept) begin
            r_last <= gnt_idx;
        end
    end

    always_comb begin
        gnt     = 2'b00;
        gnt_idx = SEL_CH0;
        case (req)
            2'b01: begin
                gnt     = 2'b01;
                gnt_idx = SEL_CH0;
            end
            2'b10: begin
                gnt     = 2'b10;
                gnt_idx = SEL_CH1;
            end
            2'b11: begin
                if (r_last == SEL_CH1) begin
                    gnt     = 2'b01;
                    gnt_idx = SEL_CH0;
                end else begin
                    gnt     = 2'b10;
                    gnt_idx = SEL_CH1;
                end
            end
            default: begin
                gnt     = 2'b00;
                gnt_idx = SEL_CH0;
            end
        endcase
    end
`endif

endmodule

// File: rtl/stream_mux_2x1.sv
// Purpose: merge two valid/ready streams onto one registered stream tagged with source index (STREAM_MUX_FIXED_PRIO_EN selects fixed priority).
// Latency: 1 cycle from input accept to out_*; sustains 1 word/cycle with simultaneous drain and load.
// Backpressure: out_ready low with a held word drops both in*_ready until the word drains.
module stream_mux_2x1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = STREAM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_sel;

    logic       w_load;
    logic [1:0] w_gnt;
    logic       w_gnt_idx;
    logic       w_accept;

    assign w_load    = ~r_out_valid | out_ready;
    assign in0_ready = w_load & w_gnt[0] & rst_n;
    assign in1_ready = w_load & w_gnt[1] & rst_n;
    assign w_accept  = (in0_ready & in0_valid) | (in1_ready & in1_valid);

    rr_arb_2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({in1_valid, in0_valid}),
        .accept  (w_accept),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // A new accept takes priority over draining, so drain+load in one cycle leaves no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= SEL_CH0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= (w_gnt_idx == SEL_CH1) ? in1_data : in0_data;
            r_out_sel   <= w_gnt_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
